word_sequencer: RTL and testbench
=================================

WORD_SEQUENCER -- requirements
Module: word_sequencer

Interface
REQ-001: Parameter TICK_CYCLES, default 100, clock cycles each sh_amt value is held (legal 2..65535).
REQ-002: Parameter LAST_SHIFT, default 12, final sh_amt value of a word (legal 0..12, so 2*sh_amt+7 <= 31).
REQ-003: clk  input  1  sole clock, all state on rising edge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: data_in  input  32  word offered by upstream source.
REQ-006: valid_in  input  1  data_in valid; transfer occurs when valid_in && ready_out at a clk edge.
REQ-007: ready_out  output  1  block can accept a word this cycle.
REQ-008: data_out  output  32  word for the shifter's data_in; stable from the LOAD cycle until the next LOAD.
REQ-009: valid_data_out  output  1  single-cycle load strobe for the shifter's valid_data_in.
REQ-010: sh_amt  output  4  current 2-bit window index for the shifter.
REQ-011: busy  output  1  high while in LOAD or STEP.
REQ-012: word_done  output  1  single-cycle pulse on the last cycle of a word's final sh_amt hold.
REQ-013: underrun  output  1  sticky flag; set when a word finishes and no next word is pending.

Function
REQ-014: Single-entry holding register (pending, pend_full) buffers one accepted word.
REQ-015: ready_out = !pend_full || (state == LOAD), combinational from registered state.
REQ-016: Accepted word written to pending at the handshake edge; pend_full set.
REQ-017: FSM states IDLE, LOAD, STEP; state register, tick counter and sh_amt all registered.
REQ-018: IDLE: if pend_full -> LOAD next edge, else stay.
REQ-019: LOAD (exactly one cycle): valid_data_out = 1, data_out = pending word, sh_amt = 0; at exit edge pend_full cleared unless a new word is accepted that same edge (then pending overwritten, pend_full stays 1); tick counter -> 0; next state STEP.
REQ-020: STEP: tick counter increments each cycle; at count TICK_CYCLES-1 it wraps to 0 and sh_amt increments by 1, except at sh_amt == LAST_SHIFT.
REQ-021: STEP with tick == TICK_CYCLES-1 and sh_amt == LAST_SHIFT: word_done = 1 that cycle; next state LOAD if pend_full else IDLE with underrun set.
REQ-022: Word period = 1 + (LAST_SHIFT+1)*TICK_CYCLES cycles LOAD to LOAD when back-to-back; no gap cycles.
REQ-023: Latency: handshake at edge k with block IDLE and pending empty -> LOAD (valid_data_out high) in cycle after edge k+1.
REQ-024: sh_amt never exceeds LAST_SHIFT; sh_amt holds last value while IDLE.
REQ-025: valid_data_out and word_done are never high for two consecutive cycles.
REQ-026: valid_in while pend_full and not LOAD: ready_out = 0, data_in ignored, no loss of pending word.
REQ-027: data_in/valid_in changes without handshake have no effect on any output.

Reset
REQ-028: rst asserted, any state: immediately state = IDLE, pend_full = 0, pending = 0, data_out = 0, valid_data_out = 0, sh_amt = 0, tick = 0, busy = 0, word_done = 0, underrun = 0; ready_out = 1.
REQ-029: rst mid-word discards both the active and pending words; first edge after deassertion behaves as IDLE/empty.
REQ-030: underrun clears only on rst.

Verification (TICK_CYCLES = 4, LAST_SHIFT = 12)
REQ-031: Single word 0xA5C3_0F96, handshake at edge k -> valid_data_out one cycle after edge k+1, data_out = 0xA5C3_0F96, sh_amt 0,1..12 each held 4 cycles, word_done once, then IDLE, underrun = 1.
REQ-032: Two words offered back-to-back -> second accepted during first word's STEP, ready_out low until LOAD, LOAD strobes exactly 53 cycles apart, underrun stays 0 until second word ends.
REQ-033: Third word offered while pending full -> ready_out = 0, word held by source, accepted in the LOAD cycle of word 2 (simultaneous drain/fill), all three words emitted in order.
REQ-034: rst asserted at sh_amt = 7 with a word pending -> all outputs to reset values same cycle, no further valid_data_out until a new handshake.
REQ-035: LAST_SHIFT = 0 -> each word: LOAD + 4 cycles at sh_amt = 0, word period 5 cycles.
REQ-036: Randomised valid_in with scoreboard -> every accepted word emitted exactly once, in order, with full sh_amt sequence.

Source files
------------

// File: rtl/word_sequencer.sv
// Word sequencer: buffers one upstream word, loads it into the shifter, then walks
// sh_amt from 0 to LAST_SHIFT holding each value for TICK_CYCLES clocks.
module word_sequencer #(
    parameter int unsigned TICK_CYCLES = 100,
    parameter int unsigned LAST_SHIFT  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [31:0] data_out,
    output logic        valid_data_out,
    output logic [3:0]  sh_amt,
    output logic        busy,
    output logic        word_done,
    output logic        underrun
);

    localparam logic [15:0] TickLast = 16'(TICK_CYCLES - 1);
    localparam logic [3:0]  ShLast   = 4'(LAST_SHIFT);

    typedef enum logic [1:0] {StIdle, StLoad, StStep} state_e;

    state_e      state_q, state_d;
    logic [31:0] pending_q, data_q;
    logic        pend_full_q, underrun_q;
    logic [15:0] tick_q;
    logic [3:0]  sh_q;
    logic        accept, tick_wrap, last_hold;

    assign accept    = valid_in && ready_out;
    assign tick_wrap = (tick_q == TickLast);
    assign last_hold = (state_q == StStep) && tick_wrap && (sh_q == ShLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (pend_full_q) state_d = StLoad;
            StLoad: state_d = StStep;
            StStep: if (last_hold) state_d = pend_full_q ? StLoad : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_out      = !pend_full_q || (state_q == StLoad);
        valid_data_out = (state_q == StLoad);
        busy           = (state_q != StIdle);
        word_done      = last_hold;
        data_out       = data_q;
        sh_amt         = sh_q;
        underrun       = underrun_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            pend_full_q <= 1'b0;
            data_q      <= '0;
            tick_q      <= '0;
            sh_q        <= '0;
            underrun_q  <= 1'b0;
        end else begin
            // A word accepted in the LOAD cycle refills the slot being drained.
            if (accept) begin
                pending_q   <= data_in;
                pend_full_q <= 1'b1;
            end else if (state_q == StLoad) begin
                pend_full_q <= 1'b0;
            end

            // data_out is captured on entry to LOAD and held until the next LOAD.
            if (state_d == StLoad) begin
                data_q <= pending_q;
                sh_q   <= '0;
            end else if ((state_q == StStep) && tick_wrap && (sh_q != ShLast)) begin
                sh_q <= sh_q + 4'd1;
            end

            if ((state_q == StStep) && !tick_wrap) begin
                tick_q <= tick_q + 16'd1;
            end else begin
                tick_q <= '0;
            end

            if (last_hold && !pend_full_q) begin
                underrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_sequencer.sv
// Bench for word_sequencer: directed and randomised words through a scoreboard, plus a
// second instance with LAST_SHIFT = 0 for the short-word case.
module tb_word_sequencer;

    localparam int T  = 4;
    localparam int L  = 12;
    localparam int WP = (L + 1) * T;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out, valid_data_out, busy, word_done, underrun;
    logic [31:0] data_out;
    logic [3:0]  sh_amt;

    logic [31:0] b_data_in = '0;
    logic        b_valid_in = 1'b0;
    logic        b_ready_out, b_valid_data_out, b_busy, b_word_done, b_underrun;
    logic [31:0] b_data_out;
    logic [3:0]  b_sh_amt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] sb[$];
    int load_cycles[$];

    word_sequencer #(.TICK_CYCLES(T), .LAST_SHIFT(L)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
        .data_out(data_out), .valid_data_out(valid_data_out), .sh_amt(sh_amt), .busy(busy),
        .word_done(word_done), .underrun(underrun)
    );

    word_sequencer #(.TICK_CYCLES(T), .LAST_SHIFT(0)) dut_b (
        .clk(clk), .rst(rst), .data_in(b_data_in), .valid_in(b_valid_in),
        .ready_out(b_ready_out), .data_out(b_data_out), .valid_data_out(b_valid_data_out),
        .sh_amt(b_sh_amt), .busy(b_busy), .word_done(b_word_done), .underrun(b_underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Per-cycle reference behaviour of the main instance, driven by observed LOAD strobes.
    int          phase = -1;
    bit          exp_under = 1'b0;
    bit          just_ended = 1'b0;
    logic [31:0] exp_word;
    always @(negedge clk) begin
        if (rst) begin
            phase = -1;
            exp_under = 1'b0;
            just_ended = 1'b0;
        end else begin
            if (phase < 0) begin
                if (valid_data_out) begin
                    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        exp_word = sb.pop_front();
                        check("load_data", data_out, exp_word);
                    end
                    check("load_sh", 32'(sh_amt), 32'd0);
                    check("load_busy", 32'(busy), 32'd1);
                    check("load_word_done", 32'(word_done), 32'd0);
                    load_cycles.push_back(cyc);
                    phase = 0;
                end else begin
                    if (just_ended) exp_under = 1'b1;
                    check("idle_busy", 32'(busy), 32'd0);
                    check("idle_word_done", 32'(word_done), 32'd0);
                end
                just_ended = 1'b0;
            end else begin
                phase++;
                check("step_vdo", 32'(valid_data_out), 32'd0);
                check("step_busy", 32'(busy), 32'd1);
                check("step_sh", 32'(sh_amt), 32'((phase - 1) / T));
                check("step_word_done", 32'(word_done), 32'(phase == WP));
                if (phase == WP) begin
                    phase = -1;
                    just_ended = 1'b1;
                end
            end
            check("underrun", 32'(underrun), 32'(exp_under));
        end
    end

    task automatic send(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        data_in  = w;
        valid_in = 1'b1;
        while (!ready_out && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("handshake_timeout", 32'(n < 500), 32'd1);
        sb.push_back(w);
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 3000), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        load_cycles.delete();
    endtask

    initial begin
        // Reset values while rst is held.
        @(negedge clk);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_vdo", 32'(valid_data_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sh", 32'(sh_amt), 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        #1 rst = 1'b0;

        // Single word: latency, full walk, underrun afterwards.
        send(32'hA5C3_0F96);
        @(negedge clk);
        check("lat_vdo_early", 32'(valid_data_out), 32'd0);
        @(negedge clk);
        check("lat_vdo", 32'(valid_data_out), 32'd1);
        check("lat_data", data_out, 32'hA5C3_0F96);
        repeat (WP + 1) @(negedge clk);
        check("single_busy", 32'(busy), 32'd0);
        check("single_sh_hold", 32'(sh_amt), 32'(L));
        check("single_underrun", 32'(underrun), 32'd1);
        check("single_data_hold", data_out, 32'hA5C3_0F96);

        // Two back-to-back words: strobes 53 cycles apart.
        do_reset();
        send(32'h1111_2222);
        send(32'h3333_4444);
        wait_drain();
        check("two_loads", 32'(load_cycles.size()), 32'd2);
        if (load_cycles.size() == 2)
            check("two_gap", 32'(load_cycles[1] - load_cycles[0]), 32'(WP + 1));
        check("two_underrun", 32'(underrun), 32'd1);

        // Three words: third waits for the LOAD of the second.
        load_cycles.delete();
        send(32'hDEAD_0001);
        send(32'hDEAD_0002);
        @(negedge clk);
        check("full_ready", 32'(ready_out), 32'd0);
        send(32'hDEAD_0003);
        wait_drain();
        check("three_loads", 32'(load_cycles.size()), 32'd3);
        if (load_cycles.size() == 3)
            check("three_gap", 32'(load_cycles[2] - load_cycles[1]), 32'(WP + 1));

        // Reset mid-word with a word pending.
        do_reset();
        send(32'h0BAD_F00D);
        send(32'h0BAD_F00E);
        begin
            int n = 0;
            while (sh_amt != 4'd7 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("sh7_timeout", 32'(n < 200), 32'd1);
        end
        #1 rst = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_ready", 32'(ready_out), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sh", 32'(sh_amt), 32'd0);
        check("mid_rst_data", data_out, 32'd0);
        check("mid_rst_vdo", 32'(valid_data_out), 32'd0);
        check("mid_rst_wd", 32'(word_done), 32'd0);
        check("mid_rst_underrun", 32'(underrun), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);

        // Randomised gaps and data through the scoreboard.
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 60)) @(negedge clk);
            send($urandom);
        end
        wait_drain();

        // LAST_SHIFT = 0 instance: 5-cycle word period.
        @(negedge clk);
        b_data_in  = 32'hCAFE_0001;
        b_valid_in = 1'b1;
        check("b_ready", 32'(b_ready_out), 32'd1);
        @(posedge clk);
        #1 b_data_in = 32'hCAFE_0002;
        @(negedge clk);
        check("b_ready_full", 32'(b_ready_out), 32'd0);
        check("b_vdo_early", 32'(b_valid_data_out), 32'd0);
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            check("b_load_vdo", 32'(b_valid_data_out), 32'd1);
            check("b_load_data", b_data_out, (w == 0) ? 32'hCAFE_0001 : 32'hCAFE_0002);
            check("b_load_sh", 32'(b_sh_amt), 32'd0);
            @(posedge clk);
            #1 b_valid_in = 1'b0;
            for (int i = 1; i <= T; i++) begin
                @(negedge clk);
                check("b_step_vdo", 32'(b_valid_data_out), 32'd0);
                check("b_step_sh", 32'(b_sh_amt), 32'd0);
                check("b_step_wd", 32'(b_word_done), 32'(i == T));
                check("b_step_busy", 32'(b_busy), 32'd1);
            end
        end
        @(negedge clk);
        check("b_end_busy", 32'(b_busy), 32'd0);
        check("b_end_underrun", 32'(b_underrun), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
